conv_start_ctrl: RTL and testbench
==================================

Name: conv_start_ctrl

Overview:
- Host-side start/done handshake controller for the convolution IP core.
- Turns a host start request into a one-cycle core start pulse, then tracks busy.
- Latches the core's done pulse into a sticky done flag, raises an interrupt, and clears on host acknowledge.
- Measures busy duration in clock cycles and flags protocol errors (start while busy).

Parameters:
- CNT_WIDTH, 16, width of busy-cycle counter cycles_o.
- TIMEOUT_CYCLES, 1000, busy cycles before forced abort; used only with CONV_CTRL_TIMEOUT_EN; must be < 2^CNT_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset.
- start_i  input  1  host start request, sampled each cycle.
- ack_i  input  1  host acknowledge; clears done_o, err_o, timeout_o.
- int_en_i  input  1  interrupt enable.
- core_done_i  input  1  done pulse from convolution core.
- core_start_o  output  1  one-cycle start pulse to core.
- busy_o  output  1  high in START and BUSY states.
- done_o  output  1  sticky completion flag.
- int_o  output  1  interrupt = done_o AND int_en_i (combinational).
- err_o  output  1  sticky: start_i seen while START/BUSY.
- timeout_o  output  1  sticky: run aborted by watchdog.
- cycles_o  output  CNT_WIDTH  busy cycles of the last/current run.

Behaviour:
- Reset: clk edge with rstn=0 → state IDLE; all outputs 0; cycles_o=0. Reset mid-run aborts silently; no done is reported.
- State register: IDLE, START, BUSY, DONE.
- IDLE:
  - start_i=1 → START.
  - ack_i clears err_o/timeout_o.
  - core_done_i ignored.
- START:
  - Lasts exactly one cycle; core_start_o=1 only in this state.
  - cycles_o cleared to 0.
  - Always → BUSY.
  - core_done_i ignored.
- BUSY:
  - cycles_o += 1 per cycle, saturating at all-ones.
  - core_done_i=1 → DONE.
- DONE:
  - done_o=1; cycles_o holds.
  - ack_i=1 → IDLE; clears done_o, err_o, timeout_o next cycle.
  - start_i=1 (with or without ack_i) is an implicit ack → START; done_o, err_o, timeout_o clear.
- Latency:
  - start_i at edge n → core_start_o and busy_o high after edge n.
  - core_done_i at edge m → done_o high after edge m.
  - Minimum start-to-done turnaround is 3 cycles.
- err_o:
  - Set when start_i=1 in START or BUSY; the request is dropped.
  - Cleared only by ack_i in IDLE/DONE, or by the implicit ack (start_i in DONE).
  - ack_i in START/BUSY is ignored.
- Simultaneous core_done_i and start_i in BUSY: err_o set and transition to DONE.
- cycles_o counts BUSY cycles only; done at the first BUSY cycle gives cycles_o=1.

Optional Feature:
- Macro CONV_CTRL_TIMEOUT_EN.
- Defined:
  - In BUSY, when cycles_o reaches TIMEOUT_CYCLES without core_done_i → DONE with timeout_o=1.
  - core_done_i in that same cycle takes priority: normal done, timeout_o=0.
- Undefined: no watchdog logic; timeout_o tied 0.

Decomposition:
- Package conv_ctrl_pkg:
  - typedef enum logic [1:0] ctrl_state_e {IDLE, START, BUSY, DONE}.
  - Default constants CNT_WIDTH_DEF=16, TIMEOUT_CYCLES_DEF=1000.
- One sub-module: conv_sat_counter (synchronous clear, enable, saturating increment, parameter WIDTH) for cycles_o.
- Top holds the FSM and sticky flags.

Test Plan:
- Normal run: reset, start_i pulse, core_done_i 5 cycles after core_start_o → core_start_o high 1 cycle, busy_o for 6 cycles, done_o=1, cycles_o=5; int_en_i=1 → int_o=1; ack_i → all flags 0 next cycle.
- Start while busy: start_i in BUSY → err_o=1, no second core_start_o; done then ack_i → err_o=0.
- Restart from DONE: start_i with done_o=1 → done_o=0, core_start_o pulse next cycle, cycles_o restarts at 0.
- Saturation: CNT_WIDTH=4, done after 20 BUSY cycles → cycles_o=15.
- Timeout (macro on, TIMEOUT_CYCLES=8): no core_done_i → DONE with timeout_o=1, cycles_o=8. Repeat with done in cycle 8 → timeout_o=0.
- Reset mid-BUSY: rstn=0 one edge → IDLE, all outputs 0; late core_done_i ignored, done_o stays 0.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared types and default constants for the convolution start/done controller.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  localparam int CNT_WIDTH_DEF      = 16;
  localparam int TIMEOUT_CYCLES_DEF = 1000;

endpackage

// File: rtl/conv_start_ctrl_if.sv
// Host/core handshake bundle for conv_start_ctrl; master drives requests, slave is the controller.
interface conv_start_ctrl_if #(
  parameter int CNT_WIDTH = conv_ctrl_pkg::CNT_WIDTH_DEF
);
  logic                 start_i;
  logic                 ack_i;
  logic                 int_en_i;
  logic                 core_done_i;
  logic                 core_start_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 int_o;
  logic                 err_o;
  logic                 timeout_o;
  logic [CNT_WIDTH-1:0] cycles_o;

  modport master (
    output start_i, ack_i, int_en_i, core_done_i,
    input  core_start_o, busy_o, done_o, int_o, err_o, timeout_o, cycles_o
  );

  modport slave (
    input  start_i, ack_i, int_en_i, core_done_i,
    output core_start_o, busy_o, done_o, int_o, err_o, timeout_o, cycles_o
  );
endinterface

// File: rtl/conv_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module conv_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/conv_start_ctrl.sv
// Start/done handshake controller for the convolution core: start pulse, busy tracking,
// sticky done/err flags and busy-cycle count. Optional watchdog under CONV_CTRL_TIMEOUT_EN.
module conv_start_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
`ifdef CONV_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic               clk,
  input  logic               rstn,
  conv_start_ctrl_if.slave   bus
);

  ctrl_state_e          state_q, state_d;
  logic                 err_q, err_d;
  logic                 tmo_q, tmo_d;
  logic                 tmo_fire;
  logic [CNT_WIDTH-1:0] cycles_q;

  // The count is cleared on entry to START so it reads 0 while the start pulse is out.
  conv_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycles (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state_d == START),
    .en   (state_q == BUSY),
    .cnt  (cycles_q)
  );

`ifdef CONV_CTRL_TIMEOUT_EN
  // Fires in the BUSY cycle that brings the count to TIMEOUT_CYCLES.
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  assign tmo_fire = (cycles_q == TMO_LAST);
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (bus.ack_i) begin
          err_d = 1'b0;
          tmo_d = 1'b0;
        end
        if (bus.start_i) state_d = START;
      end
      START: begin
        if (bus.start_i) err_d = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        if (bus.start_i) err_d = 1'b1;
        // Core completion beats the watchdog when both land together.
        if (bus.core_done_i) begin
          state_d = DONE;
        end else if (tmo_fire) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      DONE: begin
        if (bus.start_i) begin
          state_d = START;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
        end else if (bus.ack_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.core_start_o = (state_q == START);
  assign bus.busy_o       = (state_q == START) || (state_q == BUSY);
  assign bus.done_o       = (state_q == DONE);
  assign bus.int_o        = (state_q == DONE) && bus.int_en_i;
  assign bus.err_o        = err_q;
  assign bus.timeout_o    = tmo_q;
  assign bus.cycles_o     = cycles_q;

endmodule

// File: tb/tb_conv_start_ctrl.sv
// Randomized scoreboard bench for conv_start_ctrl (CNT_WIDTH=4, watchdog limit 8 when enabled).
module tb_conv_start_ctrl;

  localparam int W   = 4;
  localparam int TO  = 8;
  localparam int SAT = (1 << W) - 1;

  typedef struct {
    int cyc;
    bit err;
    bit tmo;
  } run_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  conv_start_ctrl_if #(.CNT_WIDTH(W)) bus ();

  conv_start_ctrl #(
    .CNT_WIDTH(W)
`ifdef CONV_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int   checks = 0;
  int   errors = 0;
  run_t sb_q[$];
  int   pending_starts = 0;
  bit   in_done = 1'b0;
  logic prev_cs = 1'b0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.int_en_i = 1'($urandom_range(0, 1));
  endtask

  // Reference: a run of d BUSY cycles reports min(d, 2^W-1); with the watchdog,
  // a run longer than TO stops at TO with timeout set. err reflects a dropped start.
  task automatic run(input bit from_done, input int d, input bit inj);
    int   n;
    int   p;
    bit   tmo;
    run_t r;
    n   = d;
    tmo = 1'b0;
`ifdef CONV_CTRL_TIMEOUT_EN
    if (d > TO) begin
      n   = TO;
      tmo = 1'b1;
    end
`endif
    p = $urandom_range(0, n);
    r.cyc = (n > SAT) ? SAT : n;
    r.err = inj;
    r.tmo = tmo;
    sb_q.push_back(r);
    bus.start_i = 1'b1;
    bus.ack_i   = from_done ? 1'($urandom_range(0, 1)) : 1'b0;
    pending_starts++;
    tick();
    bus.start_i = inj && (p == 0);
    bus.ack_i   = 1'($urandom_range(0, 1));
    tick();
    bus.start_i = 1'b0;
    chk("cycles_restart", 32'(bus.cycles_o), 32'd0);
    for (int k = 1; k <= n; k++) begin
      bus.start_i     = inj && (p == k);
      bus.core_done_i = !tmo && (k == n);
      bus.ack_i       = 1'($urandom_range(0, 1));
      tick();
    end
    bus.start_i     = 1'b0;
    bus.core_done_i = 1'b0;
    bus.ack_i       = 1'b0;
    in_done         = 1'b1;
  endtask

  task automatic ack_and_check();
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    chk("ack_done_clr", 32'(bus.done_o), 32'd0);
    chk("ack_err_clr", 32'(bus.err_o), 32'd0);
    chk("ack_tmo_clr", 32'(bus.timeout_o), 32'd0);
    chk("ack_busy_low", 32'(bus.busy_o), 32'd0);
    in_done = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each done rising edge, and accounts for start pulses.
  always @(negedge clk) begin
    chk("int_o", 32'(bus.int_o), 32'(bus.done_o & bus.int_en_i));
    if (bus.core_start_o) begin
      chk("start_expected", 32'(pending_starts > 0), 32'd1);
      if (pending_starts > 0) pending_starts--;
      chk("start_one_cycle", 32'(prev_cs), 32'd0);
      chk("busy_in_start", 32'(bus.busy_o), 32'd1);
    end
    if (bus.done_o && !prev_done) begin
      if (sb_q.size() == 0) begin
        chk("done_expected", 32'd0, 32'd1);
      end else begin
        run_t r;
        r = sb_q.pop_front();
        chk("run_cycles", 32'(bus.cycles_o), 32'(r.cyc));
        chk("run_err", 32'(bus.err_o), 32'(r.err));
        chk("run_timeout", 32'(bus.timeout_o), 32'(r.tmo));
        chk("done_not_busy", 32'(bus.busy_o), 32'd0);
      end
    end
    prev_cs   <= bus.core_start_o;
    prev_done <= bus.done_o;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bus.start_i     = 1'b0;
    bus.ack_i       = 1'b0;
    bus.int_en_i    = 1'b1;
    bus.core_done_i = 1'b0;
    rstn            = 1'b0;
    tick();
    tick();
    chk("rst_core_start", 32'(bus.core_start_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_int", 32'(bus.int_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_o), 32'd0);
    chk("rst_cycles", 32'(bus.cycles_o), 32'd0);
    rstn = 1'b1;
    tick();

    // Directed runs: normal, start-while-busy, shortest, saturating/timeout, restart from DONE.
    run(1'b0, 5, 1'b0);
    ack_and_check();
    run(1'b0, 5, 1'b1);
    ack_and_check();
    run(1'b0, 1, 1'b0);
    run(1'b1, 20, 1'b0);
    run(1'b1, TO, 1'b0);
    ack_and_check();

    for (int i = 0; i < 40; i++) begin
      run(in_done, $urandom_range(1, 24), ($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 1) == 1) begin
        ack_and_check();
        repeat ($urandom_range(0, 2)) begin
          bus.core_done_i = 1'($urandom_range(0, 1));
          bus.ack_i       = 1'($urandom_range(0, 1));
          tick();
        end
        bus.core_done_i = 1'b0;
        bus.ack_i       = 1'b0;
      end
    end

    // Reset in the middle of a run: no done may surface afterwards.
    bus.start_i = 1'b1;
    pending_starts++;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("midrst_busy", 32'(bus.busy_o), 32'd0);
    chk("midrst_done", 32'(bus.done_o), 32'd0);
    chk("midrst_err", 32'(bus.err_o), 32'd0);
    chk("midrst_cycles", 32'(bus.cycles_o), 32'd0);
    bus.core_done_i = 1'b1;
    tick();
    bus.core_done_i = 1'b0;
    tick();
    chk("late_done_ignored", 32'(bus.done_o), 32'd0);
    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("starts_consumed", 32'(pending_starts), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
